// File: rtl/harvos_mpu_pkg.sv
// ----------------------------------------------------------------------------
// harvos_mpu_pkg
//  Shared types and constants for the MPU region checker:
//   - access_e     : access type carried on req_type_i
//   - ATTR_*       : bit positions inside the 5-bit region attribute field
//   - cfg_sel_e    : which region field a configuration write targets
//   - region_cfg_t : one region's programmable state {base, end_addr, attr}
//   - perm_for()   : picks the permission bit that an access type needs
//  Region addresses are held at MPU_MAX_AW bits. The checker zero-extends
//  its ADDR_W-wide addresses into this width, so any ADDR_W up to
//  MPU_MAX_AW shares the same struct.
// ----------------------------------------------------------------------------
package harvos_mpu_pkg;

   localparam int MPU_MAX_AW = 64;

   typedef enum logic [1:0] {
      ACC_FETCH = 2'd0,
      ACC_READ  = 2'd1,
      ACC_WRITE = 2'd2,
      ACC_RSVD  = 2'd3
   } access_e;

   localparam int ATTR_R     = 0;
   localparam int ATTR_W     = 1;
   localparam int ATTR_X     = 2;
   localparam int ATTR_EN    = 3;
   localparam int ATTR_LOCK  = 4;
   localparam int ATTR_BITS  = 5;

   typedef enum logic [1:0] {
      CFG_BASE = 2'd0,
      CFG_END  = 2'd1,
      CFG_ATTR = 2'd2,
      CFG_RSVD = 2'd3
   } cfg_sel_e;

   typedef logic [MPU_MAX_AW-1:0] mpu_addr_t;

   typedef struct packed {
      mpu_addr_t              base;
      mpu_addr_t              end_addr;
      logic [ATTR_BITS-1:0]   attr;
   } region_cfg_t;

   // Permission bit required by an access; the reserved type is never allowed.
   function automatic logic perm_for(input access_e acc, input logic r,
                                     input logic w, input logic x);
      logic p;
      p = 1'b0;
      case (acc)
         ACC_FETCH: p = x;
         ACC_READ:  p = r;
         ACC_WRITE: p = w;
         default:   p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/mpu_region_match.sv
// ----------------------------------------------------------------------------
// mpu_region_match
//  Purely combinational window check for one region.
//  Ports:
//   addr_i  in   MPU_MAX_AW  zero-extended access address
//   cfg_i   in   region_cfg_t region base/end/attr
//   hit_o   out  1           region enabled and base <= addr <= end
//   r_o     out  1           region read permission
//   w_o     out  1           region write permission
//   x_o     out  1           region execute permission
//  A region whose base is above its end can never satisfy both compares,
//  so it never hits without any extra logic.
// ----------------------------------------------------------------------------
module mpu_region_match
   import harvos_mpu_pkg::*;
(
   input  mpu_addr_t    addr_i,
   input  region_cfg_t  cfg_i,
   output logic         hit_o,
   output logic         r_o,
   output logic         w_o,
   output logic         x_o
);

   // The lock bit only gates configuration writes in the parent.
   logic unused_lock;
   assign unused_lock = cfg_i.attr[ATTR_LOCK];

   assign hit_o = cfg_i.attr[ATTR_EN]
                & (addr_i >= cfg_i.base)
                & (addr_i <= cfg_i.end_addr);
   assign r_o   = cfg_i.attr[ATTR_R];
   assign w_o   = cfg_i.attr[ATTR_W];
   assign x_o   = cfg_i.attr[ATTR_X];

endmodule

// File: rtl/mpu_region_checker.sv
// ----------------------------------------------------------------------------
// mpu_region_checker
//  Multi-region memory protection unit placed between the core LSU/IFU and
//  the bus. Each request is checked against NUM_REGIONS programmable windows;
//  the lowest-index matching region decides, otherwise DEFAULT_ALLOW applies.
//  The verdict is registered (one cycle latency). The first denied access is
//  held in a sticky fault record until cleared.
//  Ports:
//   clk_i          in   1       clock
//   rst_ni         in   1       asynchronous reset, active low
//   req_valid_i    in   1       access check request
//   req_addr_i     in   ADDR_W  physical address
//   req_type_i     in   2       0 FETCH, 1 READ, 2 WRITE, 3 reserved (denied)
//   rsp_valid_o    out  1       verdict valid, one cycle after the request
//   rsp_allow_o    out  1       1 = access permitted (holds between requests)
//   cfg_we_i       in   1       configuration write strobe
//   cfg_idx_i      in   4       region index
//   cfg_sel_i      in   2       0 base, 1 end, 2 attr {lock,en,x,w,r}
//   cfg_wdata_i    in   ADDR_W  configuration write data
//   fault_valid_o  out  1       sticky fault flag
//   fault_addr_o   out  ADDR_W  address of first denied access
//   fault_type_o   out  2       type of first denied access
//   fault_clr_i    in   1       clears the fault flag
//  ADDR_W may be anything from 5 to MPU_MAX_AW.
// ----------------------------------------------------------------------------
module mpu_region_checker
   import harvos_mpu_pkg::*;
#(
   parameter int unsigned          NUM_REGIONS   = 4,
   parameter int unsigned          ADDR_W        = 32,
   parameter logic [ADDR_W-1:0]    RST_NX_BASE   = 32'h2000_0000,
   parameter logic [ADDR_W-1:0]    RST_NX_END    = 32'h2FFF_FFFF,
   parameter logic                 DEFAULT_ALLOW = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   input  logic [ADDR_W-1:0]    req_addr_i,
   input  logic [1:0]           req_type_i,
   output logic                 rsp_valid_o,
   output logic                 rsp_allow_o,
   input  logic                 cfg_we_i,
   input  logic [3:0]           cfg_idx_i,
   input  logic [1:0]           cfg_sel_i,
   input  logic [ADDR_W-1:0]    cfg_wdata_i,
   output logic                 fault_valid_o,
   output logic [ADDR_W-1:0]    fault_addr_o,
   output logic [1:0]           fault_type_o,
   input  logic                 fault_clr_i
);

   // Region 0 reset attribute: enabled, readable, writable, not executable.
   localparam logic [ATTR_BITS-1:0] RST0_ATTR = 5'b0_1_0_1_1;

   mpu_addr_t                  req_addr_ext;
   logic [NUM_REGIONS-1:0]     hit;
   logic [NUM_REGIONS-1:0]     perm_r;
   logic [NUM_REGIONS-1:0]     perm_w;
   logic [NUM_REGIONS-1:0]     perm_x;

   assign req_addr_ext = mpu_addr_t'(req_addr_i);

   // -------------------------------------------------------------------------
   // Region register file and per-region matchers
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
         localparam region_cfg_t RST_CFG = (gi == 0)
            ? region_cfg_t'{base:     mpu_addr_t'(RST_NX_BASE),
                            end_addr: mpu_addr_t'(RST_NX_END),
                            attr:     RST0_ATTR}
            : region_cfg_t'('0);

         region_cfg_t cfg_q;
         region_cfg_t cfg_d;
         logic        wr_en;

         // An index at or above NUM_REGIONS equals no gi, so it is dropped here.
         assign wr_en = cfg_we_i
                      & (cfg_idx_i == 4'(gi))
                      & ~cfg_q.attr[ATTR_LOCK];

         always_comb begin
            cfg_d = cfg_q;
            if (wr_en) begin
               case (cfg_sel_i)
                  CFG_BASE: cfg_d.base     = mpu_addr_t'(cfg_wdata_i);
                  CFG_END:  cfg_d.end_addr = mpu_addr_t'(cfg_wdata_i);
                  CFG_ATTR: cfg_d.attr     = cfg_wdata_i[ATTR_BITS-1:0];
                  default:  cfg_d          = cfg_q;
               endcase
            end
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               cfg_q <= RST_CFG;
            end else begin
               cfg_q <= cfg_d;
            end
         end

         mpu_region_match u_match (
            .addr_i (req_addr_ext),
            .cfg_i  (cfg_q),
            .hit_o  (hit[gi]),
            .r_o    (perm_r[gi]),
            .w_o    (perm_w[gi]),
            .x_o    (perm_x[gi])
         );
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Priority select: walk from the top index down so the lowest hit wins.
   // -------------------------------------------------------------------------
   access_e req_acc;
   logic    verdict;

   assign req_acc = access_e'(req_type_i);

   always_comb begin
      verdict = DEFAULT_ALLOW;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            verdict = perm_for(req_acc, perm_r[i], perm_w[i], perm_x[i]);
         end
      end
      // The reserved type is refused even where no region matches.
      if (req_acc == ACC_RSVD) begin
         verdict = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Response register and sticky fault record
   // -------------------------------------------------------------------------
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_allow_q, rsp_allow_d;
   logic                fault_valid_q, fault_valid_d;
   logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;
   logic [1:0]          fault_type_q, fault_type_d;
   logic                deny;

   assign deny = req_valid_i & ~verdict;

   always_comb begin
      rsp_valid_d   = req_valid_i;
      rsp_allow_d   = req_valid_i ? verdict : rsp_allow_q;
      fault_valid_d = fault_valid_q;
      fault_addr_d  = fault_addr_q;
      fault_type_d  = fault_type_q;
      // A clear in the same cycle frees the record for the new denial.
      if (deny && (!fault_valid_q || fault_clr_i)) begin
         fault_valid_d = 1'b1;
         fault_addr_d  = req_addr_i;
         fault_type_d  = req_type_i;
      end else if (fault_clr_i) begin
         fault_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q   <= 1'b0;
         rsp_allow_q   <= 1'b0;
         fault_valid_q <= 1'b0;
         fault_addr_q  <= '0;
         fault_type_q  <= '0;
      end else begin
         rsp_valid_q   <= rsp_valid_d;
         rsp_allow_q   <= rsp_allow_d;
         fault_valid_q <= fault_valid_d;
         fault_addr_q  <= fault_addr_d;
         fault_type_q  <= fault_type_d;
      end
   end

   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_allow_o   = rsp_allow_q;
   assign fault_valid_o = fault_valid_q;
   assign fault_addr_o  = fault_addr_q;
   assign fault_type_o  = fault_type_q;

endmodule

// File: tb/tb_mpu_region_checker.sv
// ----------------------------------------------------------------------------
// tb_mpu_region_checker
//  Directed vectors with hand-computed verdicts. The driver pushes each
//  expected response into a queue; a monitor pops on every rsp_valid_o and
//  compares verdict, latency and (optionally) the fault record.
// ----------------------------------------------------------------------------
module tb_mpu_region_checker;

   localparam logic [1:0] F = 2'd0;
   localparam logic [1:0] R = 2'd1;
   localparam logic [1:0] W = 2'd2;
   localparam logic [1:0] RSV = 2'd3;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic [31:0] req_addr_i;
   logic [1:0]  req_type_i;
   logic        rsp_valid_o;
   logic        rsp_allow_o;
   logic        cfg_we_i;
   logic [3:0]  cfg_idx_i;
   logic [1:0]  cfg_sel_i;
   logic [31:0] cfg_wdata_i;
   logic        fault_valid_o;
   logic [31:0] fault_addr_o;
   logic [1:0]  fault_type_o;
   logic        fault_clr_i;

   always #5 clk_i = ~clk_i;

   mpu_region_checker dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_valid_i   (req_valid_i),
      .req_addr_i    (req_addr_i),
      .req_type_i    (req_type_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_allow_o   (rsp_allow_o),
      .cfg_we_i      (cfg_we_i),
      .cfg_idx_i     (cfg_idx_i),
      .cfg_sel_i     (cfg_sel_i),
      .cfg_wdata_i   (cfg_wdata_i),
      .fault_valid_o (fault_valid_o),
      .fault_addr_o  (fault_addr_o),
      .fault_type_o  (fault_type_o),
      .fault_clr_i   (fault_clr_i)
   );

   typedef struct {
      logic        allow;
      bit          chk_f;
      logic        fv;
      logic [31:0] fa;
      logic [1:0]  ft;
      int          due;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: one comparison set per presented response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (rsp_valid_o === 1'b1) begin
            if (q.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               $display("rsp %-16s allow=%0b fault=%0b/%08h/%0d cyc=%0d",
                        e.name, rsp_allow_o, fault_valid_o, fault_addr_o, fault_type_o, cyc);
               check({e.name, "_allow"}, 32'(rsp_allow_o), 32'(e.allow));
               check({e.name, "_lat"}, cyc, e.due);
               if (e.chk_f) begin
                  check({e.name, "_fv"}, 32'(fault_valid_o), 32'(e.fv));
                  check({e.name, "_fa"}, fault_addr_o, e.fa);
                  check({e.name, "_ft"}, 32'(fault_type_o), 32'(e.ft));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic rqx(input string nm, input logic [1:0] t, input logic [31:0] a,
                      input logic allow, input bit chk_f, input logic fv,
                      input logic [31:0] fa, input logic [1:0] ft, input logic clr);
      exp_t e;
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_type_i  = t;
      req_addr_i  = a;
      fault_clr_i = clr;
      e = '{allow: allow, chk_f: chk_f, fv: fv, fa: fa, ft: ft, due: cyc + 1, name: nm};
      q.push_back(e);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      fault_clr_i = 1'b0;
   endtask

   task automatic rq(input string nm, input logic [1:0] t, input logic [31:0] a, input logic allow);
      rqx(nm, t, a, allow, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
   endtask

   task automatic rqf(input string nm, input logic [1:0] t, input logic [31:0] a, input logic allow,
                      input logic fv, input logic [31:0] fa, input logic [1:0] ft);
      rqx(nm, t, a, allow, 1'b1, fv, fa, ft, 1'b0);
   endtask

   task automatic cfg(input logic [3:0] idx, input logic [1:0] sel, input logic [31:0] d);
      @(negedge clk_i);
      cfg_we_i    = 1'b1;
      cfg_idx_i   = idx;
      cfg_sel_i   = sel;
      cfg_wdata_i = d;
      @(negedge clk_i);
      cfg_we_i    = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
      check({tag, "_rsp_allow"}, 32'(rsp_allow_o), 32'd0);
      check({tag, "_fault_valid"}, 32'(fault_valid_o), 32'd0);
      check({tag, "_fault_addr"}, fault_addr_o, 32'd0);
      check({tag, "_fault_type"}, 32'(fault_type_o), 32'd0);
   endtask

   initial begin
      exp_t e;
      rst_ni      = 1'b0;
      req_valid_i = 1'b0;
      req_addr_i  = '0;
      req_type_i  = '0;
      cfg_we_i    = 1'b0;
      cfg_idx_i   = '0;
      cfg_sel_i   = '0;
      cfg_wdata_i = '0;
      fault_clr_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check_reset_state("rst");
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Reset window: region 0 is rw, not executable.
      rqf("f_2000_0000", F, 32'h2000_0000, 1'b0, 1'b1, 32'h2000_0000, 2'd0);
      rqf("f_2fff_ffff", F, 32'h2FFF_FFFF, 1'b0, 1'b1, 32'h2000_0000, 2'd0);
      rq ("f_3000_0000", F, 32'h3000_0000, 1'b1);
      rq ("r_2000_0010", R, 32'h2000_0010, 1'b1);
      rq ("w_2000_0010", W, 32'h2000_0010, 1'b1);

      // Clear alone.
      @(negedge clk_i);
      fault_clr_i = 1'b1;
      @(negedge clk_i);
      fault_clr_i = 1'b0;
      check("clr_fv", 32'(fault_valid_o), 32'd0);

      // Region 1: 0x1000..0x1FFF read-only.
      cfg(4'd1, 2'd0, 32'h0000_1000);
      cfg(4'd1, 2'd1, 32'h0000_1FFF);
      cfg(4'd1, 2'd2, 32'h0000_0009);
      rqf("w_1800", W, 32'h0000_1800, 1'b0, 1'b1, 32'h0000_1800, 2'd2);
      check("hold_allow", 32'(rsp_allow_o), 32'd0);
      rqf("r_1800", R, 32'h0000_1800, 1'b1, 1'b1, 32'h0000_1800, 2'd2);
      rq ("r_0fff", R, 32'h0000_0FFF, 1'b1);
      rq ("r_2000", R, 32'h0000_2000, 1'b1);
      rqf("f_1000", F, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_1800, 2'd2);

      // Clear and a new denial together: the new fault is recorded.
      rqx("w_1fff_clr", W, 32'h0000_1FFF, 1'b0, 1'b1, 1'b1, 32'h0000_1FFF, 2'd2, 1'b1);

      // Overlap: region 1 executable inside region 0's window.
      cfg(4'd1, 2'd0, 32'h2000_0000);
      cfg(4'd1, 2'd1, 32'h2000_0FFF);
      cfg(4'd1, 2'd2, 32'h0000_000D);
      rqf("ovl_r0", F, 32'h2000_0100, 1'b0, 1'b1, 32'h0000_1FFF, 2'd2);
      cfg(4'd0, 2'd2, 32'h0000_0000);
      rq ("ovl_r1_f", F, 32'h2000_0100, 1'b1);
      rq ("ovl_r1_w", W, 32'h2000_0100, 1'b0);

      // Config write and request in the same cycle: old config decides.
      @(negedge clk_i);
      cfg_we_i    = 1'b1;
      cfg_idx_i   = 4'd1;
      cfg_sel_i   = 2'd2;
      cfg_wdata_i = 32'h0000_0009;
      req_valid_i = 1'b1;
      req_type_i  = F;
      req_addr_i  = 32'h2000_0100;
      e = '{allow: 1'b1, chk_f: 1'b0, fv: 1'b0, fa: 32'h0, ft: 2'd0, due: cyc + 1, name: "same_cyc_old"};
      q.push_back(e);
      @(negedge clk_i);
      cfg_we_i    = 1'b0;
      req_valid_i = 1'b0;
      rq("same_cyc_new", F, 32'h2000_0100, 1'b0);

      // Reserved type outside every region.
      rq("rsv_3000", RSV, 32'h3000_0000, 1'b0);

      // base > end never matches (region 2 would deny everything).
      cfg(4'd2, 2'd0, 32'h0000_5000);
      cfg(4'd2, 2'd1, 32'h0000_4000);
      cfg(4'd2, 2'd2, 32'h0000_0008);
      rq("inv_5000", R, 32'h0000_5000, 1'b1);
      rq("inv_4800", R, 32'h0000_4800, 1'b1);

      // Out-of-range index and reserved select are ignored.
      cfg(4'd4, 2'd2, 32'h0000_0008);
      cfg(4'd0, 2'd3, 32'h0000_0008);
      rq("ign_2800", F, 32'h2800_0000, 1'b1);

      // Lock region 1 (en, x, r) and try to move/clear it.
      cfg(4'd1, 2'd2, 32'h0000_001D);
      cfg(4'd1, 2'd0, 32'h0000_0000);
      rq("lock_w_800", W, 32'h0000_0800, 1'b1);
      cfg(4'd1, 2'd2, 32'h0000_0000);
      rq("lock_f_attr", F, 32'h2000_0100, 1'b1);

      // Reset during an active request.
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_type_i  = F;
      req_addr_i  = 32'h3000_0000;
      @(posedge clk_i);
      #1;
      check("pre_rst_valid", 32'(rsp_valid_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      check_reset_state("midrst");
      req_valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Reset values are back and the lock is gone.
      rqf("post_f_r0", F, 32'h2000_0100, 1'b0, 1'b1, 32'h2000_0100, 2'd0);
      cfg(4'd1, 2'd0, 32'h0000_1000);
      cfg(4'd1, 2'd1, 32'h0000_1FFF);
      cfg(4'd1, 2'd2, 32'h0000_0009);
      rqf("post_w_1800", W, 32'h0000_1800, 1'b0, 1'b1, 32'h2000_0100, 2'd0);
      rq ("post_r_1800", R, 32'h0000_1800, 1'b1);

      repeat (4) @(negedge clk_i);
      if (q.size() != 0) check("drain", q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
